// File: rtl/dds_phase_gen.sv
`default_nettype none
// ============================================================================
// Module   : dds_phase_gen
// Purpose  : DDS phase accumulator with burst control and period-aligned retuning
// Revision : 1.0
// ============================================================================
module dds_phase_gen #(
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 8,
  parameter int CNT_W    = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              fcw_valid,
  output logic              fcw_ready,
  input  logic [ACC_W-1:0]  fcw,
  input  logic [ADDR_W-1:0] pword,
  input  logic [CNT_W-1:0]  cycles,
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              busy,
  output logic              done
);

  localparam int                c_DR_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [c_DR_W-1:0] c_DR_LAST = c_DR_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_fcw_cur;
  logic [ACC_W-1:0]   r_fcw_pend;
  logic               r_pend_v;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_cycles;
  logic [c_DR_W-1:0]  r_drain;

  logic [ACC_W:0]     w_sum;
  logic               w_wrap;
  logic               w_xfer;
  logic               w_last;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_fcw_cur};
  assign w_wrap    = w_sum[ACC_W];
  assign w_xfer    = fcw_valid && !r_pend_v;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_last    = w_wrap && (r_cycles != '0) && (w_cnt_inc == r_cycles);
  assign fcw_ready = !r_pend_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_fcw_cur  <= '0;
      r_fcw_pend <= '0;
      r_pend_v   <= 1'b0;
      r_cnt      <= '0;
      r_cycles   <= '0;
      r_drain    <= '0;
      addr       <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) r_fcw_cur <= fcw;
          if (start) begin
            r_state  <= S_RUN;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_cycles <= cycles;
            en       <= 1'b1;
            busy     <= 1'b1;
            addr     <= pword;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
            en      <= 1'b0;
            if (w_xfer) begin
              r_fcw_pend <= fcw;
              r_pend_v   <= 1'b1;
            end
          end else begin
            r_acc <= w_sum[ACC_W-1:0];
            // Saturate so continuous bursts never roll the period count over.
            if (w_wrap && (r_cnt != '1)) r_cnt <= w_cnt_inc;
            if (w_wrap && r_pend_v) begin
              r_fcw_cur <= r_fcw_pend;
              r_pend_v  <= 1'b0;
            end else if (w_xfer) begin
              r_fcw_pend <= fcw;
              r_pend_v   <= 1'b1;
            end
            if (w_last) begin
              r_state <= S_DRAIN;
              r_drain <= '0;
              en      <= 1'b0;
            end else begin
              addr <= w_sum[ACC_W-1 -: ADDR_W] + pword;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == c_DR_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            // A word still pending at burst end becomes the idle tuning word.
            if (r_pend_v) begin
              r_fcw_cur <= r_fcw_pend;
              r_pend_v  <= 1'b0;
            end else if (w_xfer) begin
              r_fcw_cur <= fcw;
            end
          end else begin
            r_drain <= r_drain + 1'b1;
            if (w_xfer) begin
              r_fcw_pend <= fcw;
              r_pend_v   <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
